// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: mono 16-bit sample FIFO feeding an I2S transmitter (L=R), with underrun monitor
module audio_i2s_tx #(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic [15:0] underrun_count
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  logic [DW-1:0] div;
  logic [4:0] s;
  logic [31:0] sh;
  logic [15:0] last_sample, head, next_word;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic tick, fall, frame_start, empty, push, pop;
  assign tick = div == DIV_LAST;
  assign fall = tick && bclk;
  assign frame_start = fall && s == 5'd0;
  assign empty = count == '0;
  assign sample_ready = count != FULL;
  assign push = sample_valid && sample_ready;
  assign pop = frame_start && !empty;
  assign lrclk = s[4];
  assign head = mem[rd_ptr];
  // an empty FIFO at frame start repeats the previous sample
  assign next_word = empty ? last_sample : head;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      bclk <= 1'b0;
      s <= '0;
      sh <= '0;
      sdata <= 1'b0;
      last_sample <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      underrun <= 1'b0;
      underrun_count <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) bclk <= !bclk;
      underrun <= frame_start && empty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      if (fall) s <= s + 5'd1;
      if (frame_start) begin
        last_sample <= next_word;
        sh <= {next_word, next_word};
        sdata <= next_word[15];
        if (empty && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      end else if (fall) begin
        sh <= {sh[30:0], 1'b0};
        sdata <= sh[30];
      end
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized/directed checks of audio_i2s_tx against a frame-level queue model
module tb_audio_i2s_tx;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0, sel = 1'b0;
  logic [15:0] sample_in = '0;
  logic rdy4, b4, l4, s4, u4, rdy1, b1, l1, s1, u1;
  logic [15:0] c4, c1;
  logic o_rdy, o_b, o_l, o_s, o_u;
  logic [15:0] o_c;
  int checks = 0, errors = 0, t = 0, D = 4, ucnt = 0;
  logic [15:0] q[$];
  logic [15:0] cur = '0;
  bit exp_under = 0;

  audio_i2s_tx #(.BCLK_DIV(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy4), .bclk(b4), .lrclk(l4), .sdata(s4), .underrun(u4), .underrun_count(c4));
  audio_i2s_tx #(.BCLK_DIV(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy1), .bclk(b1), .lrclk(l1), .sdata(s1), .underrun(u1), .underrun_count(c1));

  assign o_rdy = sel ? rdy1 : rdy4;
  assign o_b = sel ? b1 : b4;
  assign o_l = sel ? l1 : l4;
  assign o_s = sel ? s1 : s4;
  assign o_u = sel ? u1 : u4;
  assign o_c = sel ? c1 : c4;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // t = clk edges since reset release; the I2S timing follows from t by arithmetic
  function automatic int slot_now();
    return (t / (2 * D)) % 32;
  endfunction
  function automatic logic exp_bclk();
    return ((t / D) % 2) == 1;
  endfunction
  function automatic logic exp_lr();
    return slot_now() >= 16;
  endfunction
  function automatic logic exp_sd();
    int s = slot_now();
    int idx = s == 0 ? 0 : (s <= 16 ? 16 - s : 32 - s);
    return cur[idx];
  endfunction
  function automatic bit is_rise();
    return t % (2 * D) == D;
  endfunction

  task automatic init_model();
    t = 0;
    q.delete();
    cur = '0;
    ucnt = 0;
    exp_under = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    init_model();
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    int te;
    bit fs, pop, push;
    sample_valid = v;
    sample_in = d;
    te = t + 1;
    fs = (te % (64 * D)) == 2 * D;
    pop = fs && q.size() > 0;
    push = v && q.size() < DEPTH;
    exp_under = fs && q.size() == 0;
    @(posedge clk);
    if (pop) cur = q.pop_front();
    if (push) q.push_back(d);
    if (exp_under && ucnt < 65535) ucnt++;
    t = te;
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    D = 4;
    reset_n = 1'b0;
    repeat (8) begin
      sample_valid = 1'($urandom);
      sample_in = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({o_b, o_l, o_s, o_u, o_c, o_rdy} !== {20'h0, 1'b1}) begin
        errors++;
        $display("FAIL reset_state: got %b expected %b", {o_b, o_l, o_s, o_u, o_c, o_rdy}, {20'h0, 1'b1});
      end
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    init_model();
    repeat (9) begin
      step(1'b0, 16'h0);
      checks++;
      if (o_b !== exp_bclk()) begin
        errors++;
        $display("FAIL bclk_edge@%0d: got %b expected %b", t, o_b, exp_bclk());
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] l = '0, r = '0;
    int seen = 0;
    do_reset();
    step(1'b1, 16'hA5C3);
    while (t < 260) begin
      step(1'b0, 16'h0);
      if (o_u) seen++;
      if (is_rise()) begin
        checks++;
        if (o_s !== exp_sd() || o_l !== exp_lr()) begin
          errors++;
          $display("FAIL single_bit@%0d: got sd=%b lr=%b expected sd=%b lr=%b", t, o_s, o_l, exp_sd(), exp_lr());
        end
        if (slot_now() >= 1 && slot_now() <= 16) l = {l[14:0], o_s};
        else if (t > 2 * D) r = {r[14:0], o_s};
      end
    end
    checks++;
    if (l !== 16'hA5C3 || r !== 16'hA5C3 || seen != 0) begin
      errors++;
      $display("FAIL single_word: got L=%h R=%h under=%0d expected A5C3 A5C3 0", l, r, seen);
    end
  endtask

  task automatic test_empty();
    int pulses[$];
    int ones = 0;
    do_reset();
    while (t < 520) begin
      step(1'b0, 16'h0);
      if (o_u) pulses.push_back(t);
      if (o_s) ones++;
    end
    checks++;
    if (pulses.size() != 3 || o_c !== 16'd3 || ones != 0) begin
      errors++;
      $display("FAIL empty_count: got pulses=%0d count=%0d ones=%0d expected 3 3 0", pulses.size(), o_c, ones);
    end else begin
      checks++;
      if (pulses[1] - pulses[0] != 256 || pulses[2] - pulses[1] != 256) begin
        errors++;
        $display("FAIL empty_spacing: got %0d,%0d expected 256,256", pulses[1] - pulses[0], pulses[2] - pulses[1]);
      end
    end
  endtask

  task automatic test_full();
    int k = 1, acc = 0, first_low = -1, t5 = -1, seen = 0;
    logic r;
    logic [15:0] frames [5];
    do_reset();
    while (k <= 5 && t < 400) begin
      checks++;
      if (o_rdy !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL full_ready@%0d: got %b expected %b", t, o_rdy, q.size() < DEPTH);
      end
      if (!o_rdy && first_low < 0) first_low = acc;
      r = o_rdy;
      step(1'b1, 16'(k));
      if (r) begin
        acc++;
        if (k == 5) t5 = t;
        k++;
      end
    end
    checks++;
    if (first_low != 4 || t5 != 2 * D + 1) begin
      errors++;
      $display("FAIL full_accept: got low_after=%0d t5=%0d expected 4 %0d", first_low, t5, 2 * D + 1);
    end
    for (int m = 0; m < 5; m++) frames[m] = '0;
    while (t < 1200) begin
      step(1'b0, 16'h0);
      if (o_u) seen++;
      if (is_rise() && t > 2 * D && slot_now() >= 1 && slot_now() <= 16)
        frames[(t - 2 * D) / (64 * D)] = {frames[(t - 2 * D) / (64 * D)][14:0], o_s};
    end
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (frames[m] !== 16'(m + 1)) begin
        errors++;
        $display("FAIL full_order[%0d]: got %h expected %h", m, frames[m], 16'(m + 1));
      end
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL full_underrun: got %0d expected 0", seen);
    end
  endtask

  task automatic test_hold();
    int seen = 0, bad = 0;
    do_reset();
    step(1'b1, 16'h8000);
    while (t < 1000) begin
      step(1'b0, 16'h0);
      if (o_u) seen++;
      if (o_u !== exp_under) bad++;
      if (is_rise() && o_s !== exp_sd()) bad++;
    end
    checks++;
    if (bad != 0 || seen != 3 || o_c !== 16'(ucnt) || o_c !== 16'd3) begin
      errors++;
      $display("FAIL hold: got bad=%0d pulses=%0d count=%0d expected 0 3 3", bad, seen, o_c);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 16'($urandom));
    step(1'b1, 16'($urandom));
    while (t < 76) step(1'b0, 16'h0);
    checks++;
    if (o_b !== exp_bclk() || o_s !== exp_sd() || slot_now() != 9) begin
      errors++;
      $display("FAIL mid_pre: got bclk=%b sd=%b expected %b %b", o_b, o_s, exp_bclk(), exp_sd());
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({o_b, o_l, o_s, o_u, o_c, o_rdy} !== {20'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_async: got %b expected %b", {o_b, o_l, o_s, o_u, o_c, o_rdy}, {20'h0, 1'b1});
    end
    @(negedge clk);
    reset_n = 1'b1;
    init_model();
    while (t < 8) step(1'b0, 16'h0);
    checks++;
    if (o_u !== 1'b1 || exp_under != 1 || o_s !== exp_sd()) begin
      errors++;
      $display("FAIL mid_flushed: got under=%b sd=%b expected 1 %b", o_u, o_s, exp_sd());
    end
  endtask

  task automatic test_div1();
    logic [15:0] l = '0, r = '0, w;
    int bad = 0;
    sel = 1'b1;
    D = 1;
    w = 16'($urandom) | 16'h0001;
    do_reset();
    step(1'b1, w);
    while (t < 65) begin
      step(1'b0, 16'h0);
      if (o_b !== exp_bclk()) bad++;
      if (is_rise()) begin
        if (o_s !== exp_sd() || o_l !== exp_lr()) bad++;
        if (slot_now() >= 1 && slot_now() <= 16) l = {l[14:0], o_s};
        else if (t > 2 * D) r = {r[14:0], o_s};
      end
    end
    checks++;
    if (bad != 0 || l !== w || r !== w) begin
      errors++;
      $display("FAIL div1: got bad=%0d L=%h R=%h expected 0 %h %h", bad, l, r, w, w);
    end
    sel = 1'b0;
    D = 4;
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_full();
    test_hold();
    test_mid_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
